// File: rtl/serial_pkg.sv
// Shared types, line levels and counter sizing for the serial transmitter/receiver pair.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Counter width holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// DIV-cycle bit timer: bit_end_o is high in the last cycle of each bit period.
// bit_end_nxt_o is the value bit_end_o takes after the next edge.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_end_o,
  output logic bit_end_nxt_o
);

  localparam int unsigned CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_end_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (rst_i || clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  assign bit_end_nxt_o = (cnt_d == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      bit_end_q <= (LAST == '0);
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_nxt_o;
    end
  end

  assign bit_end_o = bit_end_q;

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter with VALID/READY input and registered outputs.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  output logic             TXD,
  output logic             DONE
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept;
  logic             bit_end, bit_end_nxt;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  bit_timer #(.DIV(DIV)) u_timer (
    .clk_i         (CLK),
    .rst_i         (RST),
    .clr_i         (state_q == IDLE),
    .bit_end_o     (bit_end),
    .bit_end_nxt_o (bit_end_nxt)
  );

  assign accept = VALID & ready_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bcnt_q == BLAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // READY is only high in IDLE or the final STOP cycle, so one accept path covers both.
    if (accept) begin
      state_d = START;
      shreg_d = DIN;
      bcnt_d  = '0;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = ^DIN;
`endif
    end

    case (state_d)
      START:   txd_d = START_LVL;
      DATA:    txd_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = IDLE_LVL;
    endcase
    done_d  = (state_d == STOP) && bit_end_nxt;
    ready_d = (state_d == IDLE) || done_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      txd_q   <= IDLE_LVL;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign TXD   = txd_q;
  assign READY = ready_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Randomized and directed bench for serial_tx against a frame-position reference model.
module tb_serial_tx;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL = (W + 2 + PB) * D;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         VALID = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         READY, TXD, DONE;

  serial_tx #(.WIDTH(W), .DIV(D)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DIN   (DIN),
    .VALID (VALID),
    .READY (READY),
    .TXD   (TXD),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned done_cnt = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame is just a position 0..FL-1 into {start, data LSB first, [parity], stop}.
  bit           m_busy = 1'b0;
  int unsigned  m_pos  = 0;
  logic [W-1:0] m_word = '0;

  function automatic logic m_ready();
    return !m_busy || (m_pos == FL - 1);
  endfunction

  function automatic logic m_txd();
    int unsigned idx;
    if (!m_busy) return 1'b1;
    idx = m_pos / D;
    if (idx == 0) return 1'b0;
    if (idx <= W) return m_word[idx-1];
    if ((PB == 1) && (idx == W + 1)) return ^m_word;
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_busy <= 1'b0;
      m_pos  <= 0;
    end else if (VALID && m_ready()) begin
      m_busy <= 1'b1;
      m_pos  <= 0;
      m_word <= DIN;
    end else if (m_busy) begin
      if (m_pos == FL - 1) m_busy <= 1'b0;
      else m_pos <= m_pos + 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("txd", TXD, m_txd());
      check("ready", READY, m_ready());
      check("done", DONE, m_busy && (m_pos == FL - 1));
      if (DONE === 1'b1) done_cnt++;
    end
  end

  // Called on the negedge of cycle 1 after an accept; returns the cycle index where DONE shows.
  task automatic wait_done(output int unsigned n);
    n = 1;
    while (DONE !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) check("done_timeout", DONE, 1);
  endtask

  int unsigned n, n2, d0;

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;
    check("rst_txd", TXD, 1);
    check("rst_ready", READY, 1);
    check("rst_done", DONE, 0);
    repeat (20) @(negedge CLK);
    check("idle_txd", TXD, 1);
    check("idle_ready", READY, 1);

    VALID = 1'b1; DIN = 8'hA5;
    @(negedge CLK);
    VALID = 1'b0; DIN = W'($urandom);
    check("a5_start", TXD, 0);
    check("a5_ready", READY, 0);
    wait_done(n);
    check("a5_done_lat", n, FL);
    check("a5_ready_done", READY, 1);

    @(negedge CLK);
    VALID = 1'b1; DIN = 8'h00;
    @(negedge CLK);
    DIN = 8'hFF;
    wait_done(n);
    @(negedge CLK);
    VALID = 1'b0;
    check("b2b_gap", TXD, 0);
    check("b2b_ready", READY, 0);
    wait_done(n2);
    check("b2b_total", n + n2, 2 * FL);

    @(negedge CLK);
    VALID = 1'b1; DIN = 8'h3C;
    @(negedge CLK);
    VALID = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge CLK);
    VALID = 1'b1; DIN = 8'hFF;
    @(negedge CLK);
    VALID = 1'b0;
    wait_done(n);
    repeat (5) @(negedge CLK);
    check("ign_dones", done_cnt - d0, 1);
    check("ign_idle", TXD, 1);

    VALID = 1'b1; DIN = 8'h55;
    @(negedge CLK);
    VALID = 1'b0;
    d0 = done_cnt;
    repeat (17) @(negedge CLK);
    check("abort_bit3", TXD, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_txd", TXD, 1);
    check("abort_ready", READY, 1);
    check("abort_done", DONE, 0);
    repeat (FL) @(negedge CLK);
    check("abort_nodone", done_cnt - d0, 0);
    VALID = 1'b1; DIN = 8'h01;
    @(negedge CLK);
    VALID = 1'b0;
    wait_done(n);
    check("abort_next_lat", n, FL);

    repeat (4000) begin
      @(negedge CLK);
      VALID = ($urandom_range(3) == 0);
      DIN   = W'($urandom);
      RST   = ($urandom_range(299) == 0);
    end
    @(negedge CLK);
    VALID = 1'b0;
    RST   = 1'b0;
    repeat (FL + 5) @(negedge CLK);
    check("final_ready", READY, 1);
    check("final_txd", TXD, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
